// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the N-way stream demultiplexer:
//   lane_state_e  - per-lane holding-slot state (empty / full)
//   DROP_CNT_W    - width of the saturating dropped-transfer counter
//   sel_width()   - select width for a given lane count, never below 1 bit
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } lane_state_e;

  localparam int DROP_CNT_W = 16;

  // A 1-lane or 2-lane demux still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry holding register for a single output lane of the demux.
// A write loads the slot; a consumer handshake empties it unless a new write
// lands in the same cycle, in which case the data is replaced with no bubble.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (slot empty, data cleared)
//   wr_en      load wr_data this cycle (only issued when the slot can take it)
//   wr_data    payload to load
//   out_valid  slot is full
//   out_ready  consumer takes the slot contents this cycle
//   out_data   slot contents (zeroed while empty when ZERO_IDLE is set)
// -----------------------------------------------------------------------------
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  lane_state_e      state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (wr_en) begin
          state_next = ST_FULL;
          data_next  = wr_data;
        end
      end
      ST_FULL: begin
        // A write wins over a drain: the slot stays full with fresh data.
        if (wr_en) begin
          data_next = wr_data;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end
      end
    endcase
  end

  assign out_valid = (state_reg == ST_FULL);

  generate
    if (ZERO_IDLE) begin : g_zero_idle
      assign out_data = data_reg & {WIDTH{out_valid}};
    end else begin : g_raw_idle
      assign out_data = data_reg;
    end
  endgenerate

endmodule

// File: rtl/stream_demux_n.sv
// -----------------------------------------------------------------------------
// stream_demux_n
// Routes one valid/ready input stream to one of N_OUT output lanes, chosen per
// transfer by in_sel. Each lane has a one-entry slot, so a stalled consumer
// only blocks transfers aimed at its own lane. Selects beyond the last lane
// (possible only when N_OUT is not a power of two) are accepted, discarded,
// flagged on bad_sel for one cycle and counted in a saturating drop_cnt.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a transfer
//   in_ready   transfer accepted this cycle (combinational, 0 in reset)
//   in_sel     destination lane, sampled with in_data
//   in_data    payload
//   out_valid  per-lane slot full
//   out_ready  per-lane consumer ready
//   out_data   lane k at bits [k*WIDTH +: WIDTH]
//   bad_sel    one-cycle pulse after an out-of-range transfer was dropped
//   drop_cnt   saturating count of dropped transfers
// -----------------------------------------------------------------------------
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   N_OUT     = 4,
  parameter bit   ZERO_IDLE = 1'b1,
  localparam int  SEL_W     = sel_width(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   bad_sel,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  // One extra bit so N_OUT itself is representable for the range compare.
  localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W + 1)'(N_OUT);

  logic                  sel_ok;
  logic                  lane_blocked;
  logic                  accept;
  logic                  bad_accept;
  logic [N_OUT-1:0]      lane_wr;
  logic                  bad_sel_reg, bad_sel_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  assign sel_ok = ({1'b0, in_sel} < N_OUT_EXT);

  // The selected lane blocks only if it is full and its consumer is not
  // draining it this cycle; an out-of-range select never matches a lane.
  always_comb begin
    lane_blocked = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        lane_blocked = out_valid[k] && !out_ready[k];
      end
    end
  end

  assign in_ready   = rst_n && (!sel_ok || !lane_blocked);
  assign accept     = in_valid && in_ready;
  assign bad_accept = accept && !sel_ok;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
      assign lane_wr[gi] = accept && (in_sel == SEL_W'(gi));

      demux_slot #(
        .WIDTH     (WIDTH),
        .ZERO_IDLE (ZERO_IDLE)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (lane_wr[gi]),
        .wr_data   (in_data),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_data  (out_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_comb begin
    bad_sel_next  = bad_accept;
    drop_cnt_next = drop_cnt_reg;
    if (bad_accept && (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_next = drop_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_sel_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      bad_sel_reg  <= bad_sel_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign bad_sel  = bad_sel_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_stream_demux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_n
// Directed bench for stream_demux_n with three instances:
//   u_dut4  : N_OUT=4, ZERO_IDLE=1 (reset, routing, back-pressure, drain+write)
//   u_dut3  : N_OUT=3, ZERO_IDLE=1 (out-of-range select, saturation)
//   u_dut4z : N_OUT=4, ZERO_IDLE=0 (idle data visibility)
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_stream_demux_n;

  logic clk;
  logic rst_n;

  // u_dut4
  logic        a_in_valid, a_in_ready;
  logic [1:0]  a_in_sel;
  logic [7:0]  a_in_data;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [31:0] a_out_data;
  logic        a_bad_sel;
  logic [15:0] a_drop_cnt;

  // u_dut3
  logic        b_in_valid, b_in_ready;
  logic [1:0]  b_in_sel;
  logic [7:0]  b_in_data;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [23:0] b_out_data;
  logic        b_bad_sel;
  logic [15:0] b_drop_cnt;

  // u_dut4z
  logic        c_in_valid, c_in_ready;
  logic [1:0]  c_in_sel;
  logic [7:0]  c_in_data;
  logic [3:0]  c_out_valid, c_out_ready;
  logic [31:0] c_out_data;
  logic        c_bad_sel;
  logic [15:0] c_drop_cnt;

  int tests_run;
  int tests_failed;

  stream_demux_n #(.WIDTH(8), .N_OUT(4), .ZERO_IDLE(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .bad_sel(a_bad_sel), .drop_cnt(a_drop_cnt)
  );

  stream_demux_n #(.WIDTH(8), .N_OUT(3), .ZERO_IDLE(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .bad_sel(b_bad_sel), .drop_cnt(b_drop_cnt)
  );

  stream_demux_n #(.WIDTH(8), .N_OUT(4), .ZERO_IDLE(1'b0)) u_dut4z (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sel(c_in_sel), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .bad_sel(c_bad_sel), .drop_cnt(c_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sel = 2'd0; a_in_data = 8'h00; a_out_ready = 4'h0;
    b_in_valid = 1'b0; b_in_sel = 2'd0; b_in_data = 8'h00; b_out_ready = 3'h0;
    c_in_valid = 1'b0; c_in_sel = 2'd0; c_in_data = 8'h00; c_out_ready = 4'h0;

    // ---- power-on reset state ----
    #1;
    check("por_out_valid", 32'(a_out_valid), 32'h0);
    check("por_out_data",  a_out_data,       32'h0);
    check("por_in_ready",  32'(a_in_ready),  32'h0);
    check("por_bad_sel",   32'(a_bad_sel),   32'h0);
    check("por_drop_cnt",  32'(a_drop_cnt),  32'h0);
    #7 rst_n = 1'b1;
    tick();

    // ---- reset mid-stream with lane 2 full ----
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'h42;
    tick();
    a_in_valid = 1'b0;
    check("rst_pre_valid", 32'(a_out_valid), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(a_out_valid), 32'h0);
    check("rst_async_drop",  32'(a_drop_cnt),  32'h0);
    check("rst_async_ready", 32'(a_in_ready),  32'h0);
    #2 rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(a_in_ready), 32'h1);
    tick();

    // ---- routing sweep, all consumers ready ----
    a_out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1; a_in_sel = 2'(k); a_in_data = 8'hA0 + 8'(k);
      #1;
      check($sformatf("sweep_ready_%0d", k), 32'(a_in_ready), 32'h1);
      tick();
      check($sformatf("sweep_valid_%0d", k), 32'(a_out_valid), 32'(1) << k);
      check($sformatf("sweep_data_%0d", k),  a_out_data, (32'hA0 + 32'(k)) << (8 * k));
    end
    a_in_valid = 1'b0;
    tick();
    check("sweep_drained_valid", 32'(a_out_valid), 32'h0);
    check("sweep_drained_data",  a_out_data,       32'h0);

    // ---- back-pressure isolation on lane 1 ----
    a_out_ready = 4'b1101;
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 8'h11;
    tick();
    check("bp_fill_valid", 32'(a_out_valid), 32'h2);
    check("bp_fill_data",  a_out_data,       32'h0000_1100);
    a_in_sel = 2'd1; a_in_data = 8'h22;
    #1;
    check("bp_blocked_ready", 32'(a_in_ready), 32'h0);
    tick();
    check("bp_hold_data", a_out_data, 32'h0000_1100);
    a_in_sel = 2'd0; a_in_data = 8'h33;
    #1;
    check("bp_other_ready", 32'(a_in_ready), 32'h1);
    tick();
    check("bp_other_valid", 32'(a_out_valid), 32'h3);
    check("bp_other_data",  a_out_data,       32'h0000_1133);
    a_in_valid = 1'b0;
    a_out_ready = 4'b1111;
    tick();
    check("bp_drain_valid", 32'(a_out_valid), 32'h0);

    // ---- simultaneous drain and write on lane 3 ----
    a_out_ready = 4'b0111;
    a_in_valid = 1'b1; a_in_sel = 2'd3; a_in_data = 8'h55;
    tick();
    check("dw_fill_data", a_out_data, 32'h5500_0000);
    a_out_ready = 4'b1111;
    a_in_data = 8'h66;
    #1;
    check("dw_ready", 32'(a_in_ready), 32'h1);
    tick();
    check("dw_valid", 32'(a_out_valid), 32'h8);
    check("dw_data",  a_out_data,       32'h6600_0000);
    a_in_valid = 1'b0;
    tick();
    check("dw_drained", 32'(a_out_valid), 32'h0);

    // ---- bad select on the 3-lane instance ----
    b_out_ready = 3'b000;
    b_in_valid = 1'b1; b_in_sel = 2'd0; b_in_data = 8'hC5;
    tick();
    b_in_valid = 1'b0;
    check("bad_pre_valid", 32'(b_out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hFF;
      #1;
      check($sformatf("bad_ready_%0d", i), 32'(b_in_ready), 32'h1);
      tick();
      b_in_valid = 1'b0;
      check($sformatf("bad_pulse_%0d", i), 32'(b_bad_sel),   32'h1);
      check($sformatf("bad_cnt_%0d", i),   32'(b_drop_cnt),  32'(i + 1));
      check($sformatf("bad_lanes_%0d", i), 32'(b_out_valid), 32'h1);
      check($sformatf("bad_data_%0d", i),  32'(b_out_data),  32'h0000_00C5);
      tick();
      check($sformatf("bad_pulse_end_%0d", i), 32'(b_bad_sel), 32'h0);
    end

    // Saturation: preload the counter at its ceiling across one idle edge.
    force u_dut3.drop_cnt_reg = 16'hFFFF;
    tick();
    release u_dut3.drop_cnt_reg;
    #1;
    check("sat_preload", 32'(b_drop_cnt), 32'h0000_FFFF);
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'h01;
    tick();
    b_in_valid = 1'b0;
    check("sat_pulse", 32'(b_bad_sel),  32'h1);
    check("sat_hold",  32'(b_drop_cnt), 32'h0000_FFFF);

    // ---- ZERO_IDLE=0: drained slot still shows its data ----
    c_out_ready = 4'hF;
    c_in_valid = 1'b1; c_in_sel = 2'd0; c_in_data = 8'h7E;
    tick();
    c_in_valid = 1'b0;
    check("zi0_fill_valid", 32'(c_out_valid),      32'h1);
    check("zi0_fill_data",  32'(c_out_data[7:0]),  32'h7E);
    tick();
    check("zi0_idle_valid", 32'(c_out_valid),      32'h0);
    check("zi0_idle_data",  32'(c_out_data[7:0]),  32'h7E);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised, registered successor to the 1:2 demux: routes one valid/ready input stream to one of N_OUT output streams selected per transfer by in_sel.
- Each output lane has a one-entry holding slot, so back-pressure on one lane does not corrupt the others.
- Out-of-range selects are dropped and counted.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- WIDTH, 8, data width per lane.
- N_OUT, 4, number of output lanes (2..16).
- SEL_W, $clog2(N_OUT) (minimum 1), select width; derived, not overridden.
- ZERO_IDLE, 1, when 1 a lane's out_data reads all-zero whenever its out_valid is 0; when 0 it shows the slot contents.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a transfer.
- in_ready  output  1  block accepts the transfer this cycle.
- in_sel  input  SEL_W  destination lane, sampled with in_data.
- in_data  input  WIDTH  payload.
- out_valid  output  N_OUT  per-lane slot full.
- out_ready  input  N_OUT  per-lane consumer ready.
- out_data  output  N_OUT*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- bad_sel  output  1  one-cycle pulse: an out-of-range transfer was dropped.
- drop_cnt  output  16  saturating count of dropped transfers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All slots go EMPTY, out_valid=0, slot data=0, bad_sel=0, drop_cnt=0.
  - in_ready is forced 0 while rst_n is low.
  - A transfer in flight at reset assertion is lost; no partial state survives.
- Per-lane state machine, two states:
  - EMPTY -> FULL on an accepted transfer with in_sel=k.
  - FULL -> EMPTY on out_ready[k] with no new write to k.
  - FULL -> FULL (data replaced) when out_ready[k] and a write to k occur in the same cycle.
  - FULL holds when out_ready[k] is low.
- in_ready, combinational:
  - Equals 1 when in_sel >= N_OUT.
  - Otherwise equals (!out_valid[in_sel] || out_ready[in_sel]).
  - The out_ready -> in_ready combinational path is permitted.
- Accept and latency:
  - Accept = in_valid && in_ready.
  - Accepted data appears on out_data lane k with out_valid[k]=1 at the next clk edge (latency 1).
  - Full throughput of 1 transfer/cycle to a lane whose consumer holds out_ready high.
- Output stability:
  - While out_valid[k] && !out_ready[k], out_data lane k is stable.
  - Unselected lanes are never modified.
- Bad select:
  - in_sel >= N_OUT (only possible when N_OUT is not a power of 2) is accepted and discarded.
  - bad_sel is high for exactly the following cycle.
  - drop_cnt increments and saturates at 16'hFFFF, with no wrap.
- ZERO_IDLE=1: out_data lane k = slot data AND replicated out_valid[k].
- in_valid low: no state change except draining.
- in_data and in_sel are don't-care when in_valid is low.
- No X may propagate to outputs after reset.

Decomposition:
- Package stream_demux_pkg holds:
  - the lane state enum {ST_EMPTY, ST_FULL};
  - a sel_width function returning max(1, $clog2(n));
  - the DROP_CNT_W=16 constant.
- One natural sub-module, demux_slot: a single-lane one-entry register with wr_en, wr_data, out_valid, out_ready, out_data and the ZERO_IDLE gating.
- It is instantiated N_OUT times in a generate loop.
- The top level holds select decode, in_ready mux, bad-select detection and drop_cnt.

Test Plan:
- Reset mid-stream: assert rst_n low while lane 2 is FULL -> out_valid=4'b0000, drop_cnt=0 and in_ready=0 immediately without a clk edge; after release in_ready=1.
- Routing sweep: N_OUT=4, all out_ready=1; send data 8'hA0..8'hA3 with sel 0..3 on consecutive cycles -> each lane k shows 8'hA0+k with out_valid[k] pulsing one cycle, one cycle after its accept; other lanes read 0 (ZERO_IDLE=1).
- Back-pressure isolation: out_ready[1]=0; send 8'h11 to lane 1, then 8'h22 to lane 1, then 8'h33 to lane 0:
  - lane 1 holds 8'h11;
  - in_ready=0 while sel=1 is presented;
  - after the bench switches in_sel to 0, in_ready returns to 1, 8'h33 is accepted and lane 0 delivers 8'h33;
  - raising out_ready[1] drains 8'h11.
- Simultaneous drain and write: lane 3 FULL with 8'h55, out_ready[3]=1 and a write of 8'h66 to lane 3 in the same cycle -> next cycle out_valid[3]=1 and data 8'h66, with no bubble.
- Bad select: N_OUT=3, send sel=3 three times -> in_ready=1 each time, bad_sel pulses three times, drop_cnt=3, and no lane changes. Force drop_cnt to 16'hFFFF and send once more -> drop_cnt stays 16'hFFFF.
- ZERO_IDLE=0: lane 0 drained after carrying 8'h7E -> out_valid[0]=0 and out_data lane 0 still reads 8'h7E.
